// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - datapath/DataMemory signal bundle for the posted-write store buffer
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          MemWrite;
  logic          MemRead;
  logic [AW-1:0] adress;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          stall;
  logic          dm_MemWrite;
  logic          dm_MemRead;
  logic [AW-1:0] dm_adress;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic [CW-1:0] count;
  logic          empty;

  modport slave (
    input  MemWrite, MemRead, adress, wdata, dm_rdata,
    output rdata, stall, dm_MemWrite, dm_MemRead, dm_adress, dm_wdata, count, empty
  );

  modport master (
    output MemWrite, MemRead, adress, wdata, dm_rdata,
    input  rdata, stall, dm_MemWrite, dm_MemRead, dm_adress, dm_wdata, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - coalescing posted-write buffer with load forwarding in front of DataMemory
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;

  logic             hit;
  logic [PW-1:0]    hit_idx;
  logic             full;
  logic             store_hit;
  logic             enq;
  logic             drain;

  // Coalescing keeps at most one valid entry per address, so the match is one-hot.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr_q[i] == sb.adress)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign full      = (cnt == CW'(DEPTH));
  assign store_hit = sb.MemWrite & hit;
  assign enq       = sb.MemWrite & ~hit & ~full;
  // A store rewriting the head entry holds off its drain so the newer value is not lost.
  assign drain     = ~sb.MemRead & (cnt != '0) & ~(store_hit & (hit_idx == head));

  assign sb.stall = sb.MemWrite & ~hit & full;
  assign sb.count = cnt;
  assign sb.empty = (cnt == '0);
  assign sb.rdata = (sb.MemRead & hit) ? data_q[hit_idx] : sb.dm_rdata;

  always_comb begin
    sb.dm_MemWrite = 1'b0;
    sb.dm_MemRead  = 1'b0;
    sb.dm_adress   = sb.adress;
    sb.dm_wdata    = sb.wdata;
    if (sb.MemRead) begin
      sb.dm_MemRead = 1'b1;
    end else if (drain) begin
      sb.dm_MemWrite = 1'b1;
      sb.dm_adress   = addr_q[head];
      sb.dm_wdata    = data_q[head];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (store_hit) begin
        data_q[hit_idx] <= sb.wdata;
      end
      // tail == head only when empty (no drain) or full (no enqueue), so these never collide.
      if (enq) begin
        valid[tail]  <= 1'b1;
        addr_q[tail] <= sb.adress;
        data_q[tail] <= sb.wdata;
        tail         <= tail + 1'b1;
      end
      if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      cnt <= cnt + {{PW{1'b0}}, enq} - {{PW{1'b0}}, drain};
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized and directed self-checking bench for store_buffer
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        stall;
    logic        dmw;
    logic        dmr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          count;
    logic        empty;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) sb();
  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .sb(sb));

  logic [31:0] mem  [256] = '{default: 32'h0};
  logic [31:0] arch [256] = '{default: 32'h0};
  ent_t        q[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int tests = 0;
  int fails = 0;

  assign sb.dm_rdata = mem[sb.dm_adress[7:0]];

  always @(posedge clk) begin
    if (sb.dm_MemWrite) begin
      mem[sb.dm_adress[7:0]] <= sb.dm_wdata;
      wr_a.push_back(sb.dm_adress);
      wr_d.push_back(sb.dm_wdata);
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  // Expected outputs from the architectural view: a FIFO of pending first-writes plus the newest memory image.
  function automatic exp_t model_eval();
    exp_t e;
    logic hit = 1'b0;
    int   idx = 0;
    foreach (q[i]) if (q[i].a == sb.adress) begin hit = 1'b1; idx = i; end
    e.stall = sb.MemWrite && !hit && (q.size() == DEPTH);
    e.dmw   = !sb.MemRead && (q.size() > 0) && !(sb.MemWrite && hit && idx == 0);
    e.dmr   = sb.MemRead;
    e.adr   = e.dmw ? q[0].a : sb.adress;
    e.wd    = e.dmw ? q[0].d : sb.wdata;
    e.rdata = sb.MemRead ? arch[sb.adress[7:0]] : mem[e.adr[7:0]];
    e.count = q.size();
    e.empty = (q.size() == 0);
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      foreach (arch[i]) arch[i] = mem[i];
    end else begin
      exp_t e;
      int   idx;
      logic hit;
      e   = model_eval();
      hit = 1'b0;
      idx = 0;
      foreach (q[i]) if (q[i].a == sb.adress) begin hit = 1'b1; idx = i; end
      if (sb.MemWrite && hit) begin
        q[idx].d = sb.wdata;
        arch[sb.adress[7:0]] = sb.wdata;
      end else if (sb.MemWrite && !e.stall) begin
        q.push_back('{a: sb.adress, d: sb.wdata});
        arch[sb.adress[7:0]] = sb.wdata;
      end
      if (e.dmw) void'(q.pop_front());
    end
  end

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #2;
      e = model_eval();
      chk("stall", sb.stall, e.stall);
      chk("dm_MemWrite", sb.dm_MemWrite, e.dmw);
      chk("dm_MemRead", sb.dm_MemRead, e.dmr);
      chk("dm_adress", sb.dm_adress, e.adr);
      if (!sb.MemRead) chk("dm_wdata", sb.dm_wdata, e.wd);
      chk("rdata", sb.rdata, e.rdata);
      chk("count", sb.count, e.count);
      chk("empty", sb.empty, e.empty);
    end
  end

  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sb.MemWrite = w;
    sb.MemRead  = r;
    sb.adress   = a;
    sb.wdata    = d;
    #3;
  endtask

  initial begin
    int n0;
    int bad;
    int drained;
    rst = 1'b1;
    sb.MemWrite = 1'b0; sb.MemRead = 1'b0; sb.adress = '0; sb.wdata = '0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_count", sb.count, 0);
    chk("reset_empty", sb.empty, 1);
    chk("reset_dmw", sb.dm_MemWrite, 0);
    rst = 1'b0;

    step(1, 0, 1, 8);
    step(0, 0, 0, 0);
    chk("t1_dmw", sb.dm_MemWrite, 1);
    chk("t1_adr", sb.dm_adress, 1);
    chk("t1_wd", sb.dm_wdata, 8);
    step(0, 0, 0, 0);
    chk("t1_empty", sb.empty, 1);

    step(1, 1, 1, 32'h11);
    step(1, 1, 7, 32'h17);
    step(1, 1, 15, 32'h115);
    step(1, 1, 20, 32'h120);
    step(0, 1, 100, 0);
    chk("t2_count", sb.count, 4);
    step(1, 1, 30, 32'h130);
    chk("t2_stall_full", sb.stall, 1);
    n0 = wr_a.size();
    step(1, 0, 30, 32'h130);
    chk("t2_stall_drain", sb.stall, 1);
    chk("t2_first_drain", sb.dm_adress, 1);
    step(1, 0, 30, 32'h130);
    chk("t2_accept", sb.stall, 0);
    repeat (6) step(0, 0, 0, 0);
    chk("t2_nwr", wr_a.size() - n0, 5);
    if (wr_a.size() - n0 == 5) begin
      chk("t2_ord0", wr_a[n0], 1);
      chk("t2_ord1", wr_a[n0+1], 7);
      chk("t2_ord2", wr_a[n0+2], 15);
      chk("t2_ord3", wr_a[n0+3], 20);
      chk("t2_ord4", wr_a[n0+4], 30);
    end
    chk("t2_mem30", mem[30], 32'h130);

    step(1, 1, 7, 9);
    step(0, 1, 7, 0);
    chk("t3_fwd", sb.rdata, 9);
    step(0, 1, 15, 0);
    chk("t3_miss", sb.rdata, 32'h115);
    step(1, 1, 7, 5);
    step(0, 1, 7, 0);
    chk("t4_count", sb.count, 1);
    chk("t4_fwd", sb.rdata, 5);
    n0 = wr_a.size();
    repeat (3) step(0, 0, 0, 0);
    chk("t4_nwr", wr_a.size() - n0, 1);
    chk("t4_mem7", mem[7], 5);

    step(1, 1, 1, 8);
    step(1, 0, 1, 3);
    chk("t5_inhibit", sb.dm_MemWrite, 0);
    step(0, 0, 0, 0);
    chk("t5_dmw", sb.dm_MemWrite, 1);
    chk("t5_adr", sb.dm_adress, 1);
    chk("t5_wd", sb.dm_wdata, 3);
    step(0, 0, 0, 0);
    chk("t5_empty", sb.empty, 1);

    step(1, 1, 40, 1);
    step(1, 1, 41, 2);
    step(1, 1, 42, 3);
    step(0, 1, 0, 0);
    chk("t6_count", sb.count, 3);
    @(negedge clk);
    sb.MemWrite = 1'b0; sb.MemRead = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_count_rst", sb.count, 0);
    chk("t6_empty_rst", sb.empty, 1);
    chk("t6_dmw_rst", sb.dm_MemWrite, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    n0 = wr_a.size();
    repeat (4) step(0, 0, 0, 0);
    chk("t6_no_drain", wr_a.size() - n0, 0);
    chk("t6_mem40", mem[40], 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
           32'($urandom_range(0, 11)), $urandom);
    end
    drained = 0;
    while (drained < 20 && sb.count != 0) begin
      step(0, 0, 0, 0);
      drained++;
    end
    step(0, 0, 0, 0);
    chk("final_empty", sb.empty, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== arch[i]) bad++;
    chk("final_mem_image", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
